// File: rtl/expression_pipe.sv
// Multi-lane arithmetic/logic evaluator with per-lane accumulators, computed in
// the first stage and carried through an elastic valid/ready pipeline.
module expression_pipe #(
    parameter int                   W           = 6,
    parameter int                   NCH         = 6,
    parameter logic [NCH-1:0]       SIGNED_MASK = 6'b111000,
    parameter int                   DEPTH       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [NCH*W-1:0]        a,
    input  logic [NCH*W-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*W-1:0]        y,
    output logic [NCH-1:0]          ovf
);
    localparam int SW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;
    localparam logic [2:0] OP_XNR = 3'd6;
    localparam logic [2:0] OP_ACC = 3'd7;

    // Two's-complement overflow of x+y from the operand and result sign bits.
    function automatic logic add_sovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

    logic [W-1:0]       r_acc [NCH];
    logic [DEPTH-1:0]   r_vld;
    logic [NCH*W-1:0]   r_y   [DEPTH];
    logic [NCH-1:0]     r_ovf [DEPTH];

    logic [DEPTH-1:0]   w_take;
    logic               w_fire;
    logic [NCH*W-1:0]   w_y;
    logic [NCH*W-1:0]   w_accn;
    logic [NCH-1:0]     w_ovf_v;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            localparam bit LS = SIGNED_MASK[gi];
            logic [W-1:0]   w_a, w_b, w_acc, w_res;
            logic [W:0]     w_sum, w_dif, w_asum;
            logic [2*W-1:0] w_ea, w_eb, w_prod;
            logic [31:0]    w_sh;
            logic           w_big, w_ge, w_ovf;

            assign w_a    = a[gi*W +: W];
            assign w_b    = b[gi*W +: W];
            assign w_acc  = r_acc[gi];
            assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
            assign w_dif  = {1'b0, w_a} - {1'b0, w_b};
            assign w_asum = {1'b0, w_acc} + {1'b0, w_a};
            // Low 2W bits of the product of extended operands equal the true product mod 2^2W.
            assign w_ea   = LS ? {{W{w_a[W-1]}}, w_a} : {{W{1'b0}}, w_a};
            assign w_eb   = LS ? {{W{w_b[W-1]}}, w_b} : {{W{1'b0}}, w_b};
            assign w_prod = w_ea * w_eb;
            assign w_sh   = 32'(w_b[SW-1:0]);
            assign w_big  = (w_sh >= 32'(W));
            assign w_ge   = LS ? ($signed(w_a) >= $signed(w_b)) : (w_a >= w_b);

            // Per-lane result and overflow for the current operation.
            always_comb begin
                w_res = '0;
                w_ovf = 1'b0;
                case (op)
                    OP_ADD: begin
                        w_res = w_sum[W-1:0];
                        w_ovf = LS ? add_sovf(w_a[W-1], w_b[W-1], w_sum[W-1]) : w_sum[W];
                    end
                    OP_SUB: begin
                        w_res = w_dif[W-1:0];
                        w_ovf = LS ? add_sovf(w_a[W-1], ~w_b[W-1], w_dif[W-1]) : w_dif[W];
                    end
                    OP_MUL: begin
                        w_res = w_prod[W-1:0];
                        w_ovf = LS ? (w_prod[2*W-1:W] != {W{w_prod[W-1]}}) : (|w_prod[2*W-1:W]);
                    end
                    OP_SHL: begin
                        if (w_big) w_res = '0;
                        else       w_res = w_a << w_sh;
                    end
                    OP_SHR: begin
                        if (w_big)   w_res = LS ? {W{w_a[W-1]}} : {W{1'b0}};
                        else if (LS) w_res = $signed(w_a) >>> w_sh;
                        else         w_res = w_a >> w_sh;
                    end
                    OP_CMP: w_res = {{(W-1){1'b0}}, w_ge};
                    OP_XNR: w_res = {{(W-1){1'b0}}, ~^(w_a ^ w_b)};
                    OP_ACC: begin
                        w_res = w_asum[W-1:0];
                        w_ovf = LS ? add_sovf(w_acc[W-1], w_a[W-1], w_asum[W-1]) : w_asum[W];
                    end
                    default: begin
                        w_res = '0;
                        w_ovf = 1'b0;
                    end
                endcase
            end

            assign w_y[gi*W +: W]    = w_res;
            assign w_accn[gi*W +: W] = w_asum[W-1:0];
            assign w_ovf_v[gi]       = w_ovf;
        end

        // A stage can load whenever some stage at or after it is empty, or the output drains.
        for (gi = 0; gi < DEPTH; gi++) begin : g_take
            assign w_take[gi] = out_ready || !(&r_vld[DEPTH-1:gi]);
        end
    endgenerate

    assign in_ready  = w_take[0];
    assign w_fire    = in_valid && in_ready;
    assign out_valid = r_vld[DEPTH-1];
    assign y         = r_y[DEPTH-1];
    assign ovf       = r_ovf[DEPTH-1];

    // Accumulators update on the accept edge so back-to-back ACCs chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NCH; j++) r_acc[j] <= '0;
        end else if (w_fire && (op == OP_ACC)) begin
            for (int j = 0; j < NCH; j++) r_acc[j] <= w_accn[j*W +: W];
        end
    end

    // Elastic pipeline: each stage loads from its predecessor when allowed to advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_y[k]   <= '0;
                r_ovf[k] <= '0;
            end
        end else begin
            if (w_take[0]) begin
                r_vld[0] <= w_fire;
                r_y[0]   <= w_y;
                r_ovf[0] <= w_ovf_v;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_take[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    r_y[k]   <= r_y[k-1];
                    r_ovf[k] <= r_ovf[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_expression_pipe.sv
// Directed and randomized bench for expression_pipe against an arithmetic
// reference model that works on true integer values and range checks.
module tb_expression_pipe;
    localparam int             W     = 6;
    localparam int             NCH   = 6;
    localparam int             DEPTH = 2;
    localparam logic [NCH-1:0] SMASK = 6'b111000;
    localparam longint         MOD   = longint'(1) << W;
    localparam longint         HALF  = MOD / 2;
    localparam longint         SHM   = longint'(1) << $clog2(W);

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [NCH*W-1:0]   a, b;
    logic               out_valid;
    logic               out_ready;
    logic [NCH*W-1:0]   y;
    logic [NCH-1:0]     ovf;

    expression_pipe #(.W(W), .NCH(NCH), .SIGNED_MASK(SMASK), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*W-1:0] y;
        logic [NCH-1:0]   o;
        int               t;
    } exp_t;

    exp_t             q[$];
    longint           m_acc[NCH];
    int               dlog[$];
    bit               olog[$];
    logic [NCH*W-1:0] last_y;
    logic [NCH-1:0]   last_ovf;
    int               cyc;
    int               total;
    int               bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NCH*W-1:0] ln(input int l, input logic [W-1:0] v);
        logic [NCH*W-1:0] r;
        r = '0;
        r[l*W +: W] = v;
        return r;
    endfunction

    // Reference: evaluate each lane on its true integer value, then wrap and range-check.
    task automatic model(input logic [2:0] o, input logic [NCH*W-1:0] av, input logic [NCH*W-1:0] bv,
                         output logic [NCH*W-1:0] ey, output logic [NCH-1:0] eo);
        longint pa, pb, va, vb, vc, lo, hi, t;
        int     sh;
        bit     sg;
        ey = '0;
        eo = '0;
        for (int i = 0; i < NCH; i++) begin
            pa = av[i*W +: W];
            pb = bv[i*W +: W];
            sg = SMASK[i];
            va = (sg && pa >= HALF) ? pa - MOD : pa;
            vb = (sg && pb >= HALF) ? pb - MOD : pb;
            vc = (sg && m_acc[i] >= HALF) ? m_acc[i] - MOD : m_acc[i];
            lo = sg ? -HALF : 0;
            hi = sg ? HALF - 1 : MOD - 1;
            sh = int'(pb % SHM);
            case (o)
                3'd0: t = va + vb;
                3'd1: t = va - vb;
                3'd2: t = va * vb;
                3'd3: t = (sh >= W) ? 0 : (pa << sh);
                3'd4: begin
                    if (sh >= W) t = (va < 0) ? -1 : 0;
                    else         t = va >>> sh;
                end
                3'd5: t = (va >= vb) ? 1 : 0;
                3'd6: t = ($countones(pa ^ pb) % 2 == 0) ? 1 : 0;
                default: begin
                    t = vc + va;
                    m_acc[i] = t & (MOD - 1);
                end
            endcase
            eo[i] = ((o <= 3'd2) || (o == 3'd7)) && ((t < lo) || (t > hi));
            ey[i*W +: W] = t[W-1:0];
        end
    endtask

    // One clock: check handshake outputs at the negedge, update the model, advance.
    task automatic cycle(output bit took);
        exp_t e;
        @(negedge clk);
        took = 1'b0;
        if (!reset) begin
            chk("in_ready", in_ready, (q.size() < DEPTH) || out_ready);
            chk("out_valid", out_valid, (q.size() > 0) && (cyc - q[0].t >= DEPTH));
            if (out_valid && out_ready && q.size() > 0) begin
                chk("y", y, q[0].y);
                chk("ovf", ovf, q[0].o);
                last_y   = y;
                last_ovf = ovf;
                dlog.push_back(int'(y[W-1:0]));
                olog.push_back(ovf[0]);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                model(op, a, b, e.y, e.o);
                e.t = cyc;
                q.push_back(e);
                took = 1'b1;
            end
        end else begin
            q.delete();
            for (int i = 0; i < NCH; i++) m_acc[i] = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit tk;
        for (int i = 0; i < n; i++) cycle(tk);
    endtask

    task automatic send(input logic [2:0] o, input logic [NCH*W-1:0] av, input logic [NCH*W-1:0] bv);
        bit tk;
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        cycle(tk);
        chk("send_accepted", tk, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit tk;
        int k;
        int nst;
        int acc_y[4];
        bit acc_o[4];
        acc_y = '{20, 40, 60, 16};
        acc_o = '{1'b0, 1'b0, 1'b0, 1'b1};
        total = 0;
        bad = 0;
        cyc = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) m_acc[i] = 0;

        idle(3);
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1'b1);

        send(3'd0, ln(0, 6'd63) | ln(3, 6'd31), ln(0, 6'd1) | ln(3, 6'd1));
        idle(3);
        chk("add_l0", last_y[0 +: W], 0);
        chk("add_l3", last_y[3*W +: W], 6'b100000);
        chk("add_ovf0", last_ovf[0], 1'b1);
        chk("add_ovf3", last_ovf[3], 1'b1);

        send(3'd4, ln(3, 6'b111000) | ln(0, 6'd56), ln(3, 6'd2) | ln(0, 6'd2));
        idle(3);
        chk("shr_l3", last_y[3*W +: W], 6'b111110);
        chk("shr_l0", last_y[0 +: W], 14);

        send(3'd5, ln(3, 6'h3f) | ln(0, 6'd63), ln(3, 6'd1) | ln(0, 6'd1));
        idle(3);
        chk("cmp_l3", last_y[3*W +: W], 0);
        chk("cmp_l0", last_y[0 +: W], 1);

        send(3'd2, ln(4, 6'b111101) | ln(1, 6'd9), ln(4, 6'd5) | ln(1, 6'd9));
        idle(3);
        chk("mul_l4", last_y[4*W +: W], 6'b110001);
        chk("mul_ovf4", last_ovf[4], 1'b0);
        chk("mul_l1", last_y[W +: W], 17);
        chk("mul_ovf1", last_ovf[1], 1'b1);

        // Back-pressure: consumer stalls for the first four cycles.
        dlog.delete();
        k = 1;
        nst = 0;
        for (int c = 0; c < 40 && (k <= 5 || q.size() > 0); c++) begin
            out_ready = (c >= 4);
            in_valid = (k <= 5);
            op = 3'd0;
            a = ln(0, W'(k));
            b = '0;
            cycle(tk);
            if (tk) begin
                k++;
                if (c < 4) nst++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_accepts", nst, 2);
        chk("bp_count", dlog.size(), 5);
        for (int i = 0; i < 5 && i < dlog.size(); i++) chk("bp_order", dlog[i], i + 1);

        dlog.delete();
        olog.delete();
        for (int i = 0; i < 4; i++) send(3'd7, ln(0, 6'd20), '0);
        idle(3);
        chk("acc_count", dlog.size(), 4);
        for (int i = 0; i < 4 && i < dlog.size(); i++) begin
            chk("acc_y", dlog[i], acc_y[i]);
            chk("acc_ovf", olog[i], acc_o[i]);
        end

        // Reset with two entries in flight, then a reset cycle that coincides with an ACC offer.
        out_ready = 1'b0;
        send(3'd0, ln(0, 6'd9), '0);
        send(3'd0, ln(0, 6'd10), '0);
        reset = 1'b1;
        cycle(tk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 3'd7;
        a = ln(0, 6'd7);
        cycle(tk);
        in_valid = 1'b0;
        reset = 1'b0;
        dlog.delete();
        chk("midrst_out_valid", out_valid, 1'b0);
        idle(4);
        chk("midrst_no_ghosts", dlog.size(), 0);
        send(3'd7, ln(0, 6'd5), '0);
        idle(3);
        chk("midrst_acc_count", dlog.size(), 1);
        chk("midrst_acc_y", last_y[0 +: W], 5);

        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a = (NCH*W)'({$urandom(), $urandom()});
            b = (NCH*W)'({$urandom(), $urandom()});
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(tk);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) cycle(tk);
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
